// File: rtl/rr_arbiter4_v_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg_v (package)
// Purpose  : Shared constants and helpers for the small arbiter family.
//            NUM_REQ  - number of requesters served by the 4-way arbiters
//            IDLE/GRANT/GAP - 2-bit FSM state codes (2'b11 is unused)
//            onehot4  - 2-bit index to 4-bit one-hot vector
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg_v;

   localparam int NUM_REQ = 4;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] GRANT = 2'b01;
   localparam logic [1:0] GAP   = 2'b10;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      logic [3:0] v;
      v = 4'b0001 << idx;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4_v_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_v_if
// Purpose  : Request/grant bundle between 4 requesters and the arbiter.
//   req     [3:0] level requests, bit n = requester n
//   gnt     [3:0] registered one-hot grant (zero when resource is free)
//   gnt_id  [1:0] index of current owner, holds last owner when gnt==0
//   busy          OR of gnt bits
//   any_req       combinational OR of req bits
// Modports : master = requester side, slave = arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter4_v_if;

   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       any_req;

   modport master (
      output req,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  any_req
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_id,
      output busy,
      output any_req
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter4_v_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4_v
// Purpose  : Combinational rotate-priority encoder. Returns the first set
//            request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   req   [3:0] request vector
//   ptr   [1:0] highest-priority position
//   idx   [1:0] selected requester (equals ptr when nothing is requesting)
//   valid       OR of req bits
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4_v
   import arb_pkg_v::*;
(
   input  wire logic [3:0] req,
   input  wire logic [1:0] ptr,
   output logic      [1:0] idx,
   output logic            valid
);

   assign valid = |req;

   // Scan from the lowest priority upward so the closest set bit to ptr
   // is the last (and therefore winning) assignment.
   always_comb begin
      idx = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[ptr + 2'(i)]) begin
            idx = ptr + 2'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4_v.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_v
// Purpose  : 4-way round-robin arbiter for one shared resource. Grants are
//            registered and one-hot, held while the owner keeps requesting,
//            rotated after HOLD_MAX cycles when another requester waits, and
//            separated by one dead cycle between owners.
//   i_clk     system clock
//   i_rst_n   synchronous active-low reset
//   bus       rr_arbiter4_v_if.slave (req in; gnt, gnt_id, busy, any_req out)
// Parameter: HOLD_MAX - max consecutive grant cycles before forced rotation
//            (legal 1..255)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4_v
   import arb_pkg_v::*;
#(
   parameter int HOLD_MAX = 8
)(
   input  wire logic        i_clk,
   input  wire logic        i_rst_n,
   rr_arbiter4_v_if.slave   bus
);

   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] c_hold_max = CW'(HOLD_MAX);

   logic [1:0]    r_state;
   logic [1:0]    r_ptr;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_gnt;
   logic [1:0]    r_gnt_id;
   logic          r_busy;

   logic [1:0]    w_pick_idx;
   logic          w_pick_valid;
   logic          w_others;
   logic          w_release;

   rr_pick4_v u_pick (
      .req   (bus.req),
      .ptr   (r_ptr),
      .idx   (w_pick_idx),
      .valid (w_pick_valid)
   );

   // Contenders other than the current owner; only meaningful in GRANT.
   assign w_others  = |(bus.req & ~onehot4(r_gnt_id));
   // Owner drop and timeout-with-contender give the same result.
   assign w_release = !bus.req[r_gnt_id] || ((r_cnt == c_hold_max) && w_others);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= 2'd0;
         r_cnt    <= '0;
         r_gnt    <= 4'b0000;
         r_gnt_id <= 2'd0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, GAP: begin
               // GAP arbitrates exactly like IDLE; the dead cycle comes from
               // the release edge having already cleared the grant.
               if (w_pick_valid) begin
                  r_state  <= GRANT;
                  r_gnt    <= onehot4(w_pick_idx);
                  r_gnt_id <= w_pick_idx;
                  r_busy   <= 1'b1;
                  r_cnt    <= CW'(1);
               end else begin
                  r_state  <= IDLE;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_state <= GAP;
                  r_gnt   <= 4'b0000;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_gnt_id + 2'd1;
                  r_cnt   <= '0;
               end else if (r_cnt != c_hold_max) begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= 4'b0000;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.gnt_id  = r_gnt_id;
   assign bus.busy    = r_busy;
   assign bus.any_req = w_pick_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4_v.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4_v
// Purpose  : Self-checking bench for rr_arbiter4_v (HOLD_MAX=4). Directed
//            scenarios followed by randomized requests and resets, all
//            compared against an ownership-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4_v;

   localparam int HOLD = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   // Reference model: who owns the resource, for how long, and where the
   // round-robin scan starts. A released resource simply has no owner; the
   // next edge arbitrates, which yields the single dead cycle.
   int         m_owner;
   int         m_ptr;
   int         m_cnt;
   logic [1:0] m_id;

   rr_arbiter4_v_if bus ();

   rr_arbiter4_v #(.HOLD_MAX(HOLD)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [3:0] r;
      bit         others;
      r = bus.req;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_id = 2'd0;
      end else if (m_owner >= 0) begin
         others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
         if (!r[m_owner] || (m_cnt == HOLD && others)) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_cnt   = 0;
         end else if (m_cnt < HOLD) begin
            m_cnt++;
         end
      end else if (r != 4'b0000) begin
         for (int i = 0; i < 4; i++)
            if (m_owner < 0 && r[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
         m_id  = 2'(m_owner);
         m_cnt = 1;
      end
   endtask

   // One clock: advance the model at the edge, then compare just after it.
   task automatic step();
      logic [3:0] exp_gnt;
      @(posedge clk);
      model_edge();
      #1;
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("gnt",     32'(bus.gnt),     32'(exp_gnt));
      chk("gnt_id",  32'(bus.gnt_id),  32'(m_id));
      chk("busy",    32'(bus.busy),    32'(exp_gnt != 4'b0000));
      chk("any_req", 32'(bus.any_req), 32'(bus.req != 4'b0000));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_owner  = -1; m_ptr = 0; m_cnt = 0; m_id = 2'd0;
      rst_n    = 1'b0;
      bus.req  = 4'b1111;

      // Reset held two edges with all requests high.
      step();
      step();
      chk("rst_gnt",  32'(bus.gnt),    32'h0);
      chk("rst_busy", 32'(bus.busy),   32'h0);
      chk("rst_id",   32'(bus.gnt_id), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rst_rel_gnt", 32'(bus.gnt), 32'h1);

      // Single request, release, gap, stay idle.
      do_reset();
      bus.req = 4'b0100;
      step();
      chk("single_gnt", 32'(bus.gnt),    32'h4);
      chk("single_id",  32'(bus.gnt_id), 32'h2);
      bus.req = 4'b0000;
      step();
      chk("single_gap", 32'(bus.gnt), 32'h0);
      step();
      chk("single_idle", 32'(bus.gnt), 32'h0);
      chk("single_hold_id", 32'(bus.gnt_id), 32'h2);

      // Full contention: 4 cycles per owner, one gap, rotating 0..3.
      do_reset();
      bus.req = 4'b1111;
      for (int j = 0; j < 21; j++) begin
         int k;
         step();
         k = (j / 5) % 4;
         chk("contend", 32'(bus.gnt), ((j % 5) < 4) ? (32'h1 << k) : 32'h0);
      end

      // Lone owner is never rotated out.
      do_reset();
      bus.req = 4'b0010;
      for (int j = 0; j < 20; j++) begin
         step();
         chk("lone_owner", 32'(bus.gnt), 32'h2);
      end

      // Pointer wrap 3 -> 0, then 0 -> 1 scan finds 3.
      do_reset();
      bus.req = 4'b1000;
      step();
      chk("ptr_own3", 32'(bus.gnt), 32'h8);
      bus.req = 4'b0001;
      step();
      bus.req = 4'b1001;
      step();
      chk("ptr_wrap0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b1000;
      step();
      bus.req = 4'b1001;
      step();
      chk("ptr_next3", 32'(bus.gnt), 32'h8);

      // Reset while requester 2 owns the resource.
      do_reset();
      bus.req = 4'b0100;
      step();
      step();
      bus.req = 4'b0110;
      rst_n   = 1'b0;
      step();
      chk("midrst_gnt", 32'(bus.gnt), 32'h0);
      rst_n = 1'b1;
      step();
      chk("midrst_after", 32'(bus.gnt), 32'h2);

      // Randomized traffic; requests tend to persist so timeouts occur.
      for (int j = 0; j < 1500; j++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/rr_arbiter4_v.md
Name: rr_arbiter4_v

Overview:
- Round-robin arbiter sharing one downstream resource (e.g. a shared gate/datapath unit) between 4 requesters.
- Issues a registered one-hot grant and holds it while the owner keeps requesting.
- Forces rotation after a hold limit when another requester is waiting.
- Inserts one dead cycle between owners so the shared resource's input muxing never overlaps.

Parameters:
HOLD_MAX, 8, max consecutive grant cycles for one owner before forced rotation (legal 1..255)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst_n  input  1  synchronous reset, active-low
i_req  input  4  level requests, bit n = requester n
o_gnt  output  4  one-hot grant (all zero when nobody owns the resource)
o_gnt_id  output  2  encoded index of current owner; holds last owner when o_gnt==0
o_busy  output  1  OR of o_gnt bits (resource owned this cycle)
o_any_req  output  1  combinational OR of i_req bits

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low. While i_rst_n==0 at a rising edge: state=IDLE, o_gnt=4'b0000, o_gnt_id=2'd0, o_busy=0, priority pointer=0, hold counter=0. o_any_req is unaffected by reset.
- Registered outputs: o_gnt, o_gnt_id and o_busy come straight from registers.
- States: IDLE, GRANT, GAP. 2-bit encoding, value 2'b11 unused and recovers to IDLE.
- Pick function: first requester with i_req set, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE or GAP: if o_any_req at the edge, then o_gnt=onehot(pick), o_gnt_id=pick, hold counter=1, state goes to GRANT. Otherwise state goes to IDLE.
- Latency: request sampled at edge k gives o_gnt high after edge k (1 cycle).
- GAP: lasts exactly 1 cycle with o_gnt==0. It does not delay arbitration further (same transitions as IDLE).
- GRANT, release: owner's i_req==0 at the edge. Then o_gnt goes to 0, ptr=(owner+1) mod 4, counter=0, state goes to GAP.
- GRANT, forced rotation: counter==HOLD_MAX and any other i_req bit set. Then same as release. The owner's still-high request re-enters rotation at lowest priority.
- GRANT, otherwise: keep grant; counter increments and saturates at HOLD_MAX. With no contender, the owner keeps the grant indefinitely.
- Simultaneous owner-drop and timeout: treated as release (identical result).
- Requests from non-owners during GRANT or GAP: ignored until the next arbitration edge. There is no latching, so a pulse that deasserts before then is lost (requesters must hold i_req until granted).
- Reset mid-grant: grant drops at that same edge. ptr returns to 0, so the next arbitration favours requester 0.
- Invariant: $onehot0(o_gnt) always. o_busy==|o_gnt.
- Counter width: $clog2(HOLD_MAX+1).

Decomposition:
- Shared package arb_pkg_v:
  - NUM_REQ=4
  - state localparams IDLE=2'b00, GRANT=2'b01, GAP=2'b10
  - function onehot4(idx)
- One natural sub-module: rr_pick4_v, a combinational rotate-priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: idx[1:0], valid.
  - valid is built from the existing 4-input OR component.
  - Reusable by later arbiters.

Test Plan:
1. Reset: hold i_rst_n=0 for 2 edges with i_req=4'b1111 -> o_gnt=0000, o_busy=0, o_gnt_id=0. Release reset -> o_gnt=0001 one cycle later.
2. Single request: i_req=0100 from IDLE -> o_gnt=0100, o_gnt_id=2 after 1 edge. Drop req -> o_gnt=0000 for exactly 1 cycle (GAP), then stays 0000.
3. Full contention, HOLD_MAX=4, i_req=1111 held -> grant sequence 0001(4 cyc), gap, 0010(4), gap, 0100(4), gap, 1000(4), gap, 0001.
4. Timeout without contender: HOLD_MAX=4, i_req=0010 held 20 cycles -> o_gnt=0010 continuously, no gap.
5. Pointer fairness: owner 3 releases while i_req=1001 -> after GAP, grant goes to 0 (ptr wrapped 3 to 0). Then owner 0 releases with i_req=1001 -> next grant is 3.
6. Reset mid-operation: o_gnt=0100 with counter=2, assert i_rst_n=0 for one edge with i_req=0110 held -> o_gnt=0000 at that edge. After reset, grant 0010 (ptr=0 scan finds 1 first).
